// File: rtl/interval_timer_pkg.sv
// Shared types and constants for the interval timer: FSM state encoding and BCD digit limits.
package interval_timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int         DIGIT_W   = 4;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/interval_timer_bcd_digit.sv
// One BCD decade counter; rolls 9 -> 0 and signals carry into the next decade.
module bcd_digit
    import interval_timer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic               hold,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && !hold) begin
            q <= (q == DIGIT_MAX) ? '0 : q + 4'd1;
        end
    end

    assign carry = en && (q == DIGIT_MAX);

endmodule

// File: rtl/interval_timer.sv
// Counts delay ticks between start and stop in native packed BCD, saturating at all nines.
module interval_timer
    import interval_timer_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                    busy,
    output logic                    valid,
    output logic                    overflow
);

    state_t state_q, state_d;

    logic [DIGITS:0]   en_chain;
    logic [DIGITS-1:0] nine;
    logic              sat;
    logic              zero_cnt;

    // Start clears the count in every state, so it shares the clear path of the digits.
    assign zero_cnt    = clear || start;
    assign en_chain[0] = tick && (state_q == S_RUN);
    assign sat         = &nine;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (zero_cnt),
            .en    (en_chain[i]),
            .hold  (sat),
            .q     (bcd[i*DIGIT_W +: DIGIT_W]),
            .carry (en_chain[i+1])
        );
        assign nine[i] = (bcd[i*DIGIT_W +: DIGIT_W] == DIGIT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before any branch so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else if (start) begin
            state_d = S_RUN;
        end else if (state_q == S_RUN && stop) begin
            state_d = S_DONE;
        end
    end

    // A carry out of the top decade means a tick arrived while already at all nines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (zero_cnt) begin
            overflow <= 1'b0;
        end else if (en_chain[DIGITS]) begin
            overflow <= 1'b1;
        end
    end

    assign busy  = (state_q == S_RUN);
    assign valid = (state_q == S_DONE);

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench: decimal reference model compared every cycle, plus directed literal checks.
module tb_interval_timer;

    localparam int DIGITS = 4;
    localparam int FULL   = 9999;

    logic        clk;
    logic        rst_n;
    logic        tick, start, stop, clear;
    logic [15:0] bcd;
    logic        busy, valid, overflow;

    int n_checks = 0;
    int n_fail   = 0;

    interval_timer #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .bcd      (bcd),
        .busy     (busy),
        .valid    (valid),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain decimal count and a mode name.
    typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;
    mode_t m_mode;
    int    m_count;
    bit    m_ovf;

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int          p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'((n / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE; m_count = 0; m_ovf = 0;
        end else if (clear) begin
            m_mode = M_IDLE; m_count = 0; m_ovf = 0;
        end else if (start) begin
            m_mode = M_RUN; m_count = 0; m_ovf = 0;
        end else if (m_mode == M_RUN) begin
            if (tick) begin
                if (m_count == FULL) m_ovf = 1;
                else m_count = m_count + 1;
            end
            if (stop) m_mode = M_DONE;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("model_bcd", {16'h0, bcd}, {16'h0, to_bcd(m_count)});
            check("model_flags", {29'h0, busy, valid, overflow},
                  {29'h0, m_mode == M_RUN, m_mode == M_DONE, m_ovf});
        end
    end

    task automatic drive(input logic t, input logic s, input logic p, input logic c);
        @(negedge clk);
        tick = t; start = s; stop = p; clear = c;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0);
    endtask

    task automatic settle();
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 3,
                  $urandom_range(0, 199) < 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tick = 0; start = 0; stop = 0; clear = 0;
        #1;
        check("reset_bcd", {16'h0, bcd}, 32'h0);
        check("reset_flags", {29'h0, busy, valid, overflow}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic measurement
        drive(0, 1, 0, 0);
        ticks(250);
        drive(0, 0, 1, 0);
        settle();
        check("basic_bcd", {16'h0, bcd}, 32'h0250);
        check("basic_flags", {29'h0, busy, valid, overflow}, 32'h2);

        // Decade carry across three digits
        drive(0, 1, 0, 0);
        ticks(999);
        settle();
        check("carry_pre", {16'h0, bcd}, 32'h0999);
        ticks(1);
        settle();
        check("carry_post", {16'h0, bcd}, 32'h1000);

        // Saturation
        drive(0, 1, 0, 0);
        ticks(9999);
        settle();
        check("sat_full_noovf", {16'h0, bcd, 15'h0, overflow}, 32'h9999_0000);
        ticks(1);
        settle();
        check("sat_ovf", {16'h0, bcd, 15'h0, overflow}, 32'h9999_0001);
        ticks(5);
        drive(0, 0, 1, 0);
        settle();
        check("sat_done", {16'h0, bcd, 13'h0, busy, valid, overflow}, 32'h9999_0003);

        // Collisions
        drive(0, 1, 0, 0);
        ticks(7);
        drive(1, 0, 1, 0);
        settle();
        check("stop_tick", {16'h0, bcd, 14'h0, busy, valid}, 32'h0008_0001);
        drive(0, 0, 0, 1);
        drive(0, 1, 1, 0);
        settle();
        check("start_stop_idle", {31'h0, busy}, 32'h1);
        ticks(3);
        drive(0, 1, 0, 1);
        settle();
        check("clear_start", {16'h0, bcd, 14'h0, busy, valid}, 32'h0);

        // Ignored events
        ticks(4);
        drive(0, 0, 1, 0);
        settle();
        check("idle_ignore", {16'h0, bcd, 14'h0, busy, valid}, 32'h0);
        drive(0, 1, 0, 0);
        ticks(12);
        drive(0, 0, 1, 0);
        ticks(6);
        drive(0, 0, 1, 0);
        settle();
        check("done_freeze", {16'h0, bcd, 14'h0, busy, valid}, 32'h0012_0001);
        drive(0, 1, 0, 0);
        settle();
        check("done_restart", {16'h0, bcd, 14'h0, busy, valid}, 32'h0000_0002);

        // Random traffic from zero, then from near full scale
        random_phase(3000);
        drive(0, 1, 0, 0);
        ticks(9995);
        random_phase(2000);

        // Asynchronous reset mid-run
        drive(0, 1, 0, 0);
        ticks(42);
        drive(0, 0, 0, 0);
        check("pre_reset", {16'h0, bcd, 15'h0, busy}, 32'h0042_0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {16'h0, bcd, 13'h0, busy, valid, overflow}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
